cvxif_issue_arbiter: RTL
========================

Name: cvxif_issue_arbiter

Overview:
- Shares one CV-X-IF coprocessor (for example the example coprocessor) between NrPorts cores or requesters.
- Arbitrates the issue channel round-robin.
- Remaps each requester's instruction ID onto a coprocessor-side ID taken from a free pool.
- Holds an outstanding-transaction table so that out-of-order results route back to the requester that issued them, carrying that requester's original ID.
- Sits between the cva6 instances and the single coprocessor in a multi-hart top level.

Parameters:
- NrPorts, 2: number of requesters; must be >= 2.
- IdWidth, 3: ID width on both sides; table depth NrSlots = 2**IdWidth.
- RegWidth, 64: operand and result width (riscv::XLEN).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_issue_valid_i  in  NrPorts  per-port issue request
- req_issue_ready_o  out  NrPorts  per-port issue handshake complete
- req_issue_accept_o  out  1  coprocessor accepted the instruction; qualified by the ready of the granted port
- req_issue_instr_i  in  NrPorts*32  instruction words
- req_issue_rs_i  in  NrPorts*2*RegWidth  source operands
- req_issue_id_i  in  NrPorts*IdWidth  requester-local IDs
- req_result_valid_o  out  NrPorts  result for this port
- req_result_ready_i  in  NrPorts  port accepts result
- req_result_id_o  out  IdWidth  original requester ID, shared bus
- req_result_data_o  out  RegWidth  result data, shared bus
- req_result_rd_o  out  5  destination register
- req_result_we_o  out  1  write enable
- cop_issue_valid_o / cop_issue_ready_i / cop_issue_accept_i  out/in/in  1 each  downstream issue handshake
- cop_issue_instr_o  out  32  forwarded instruction
- cop_issue_rs_o  out  2*RegWidth  forwarded operands
- cop_issue_id_o  out  IdWidth  allocated slot ID
- cop_result_valid_i / cop_result_ready_o  in/out  1 each  downstream result handshake
- cop_result_id_i  in  IdWidth  slot ID of the result
- cop_result_data_i  in  RegWidth  result data
- cop_result_rd_i  in  5  destination register
- cop_result_we_i  in  1  write enable
- outstanding_o  out  IdWidth+1  number of busy slots
- spurious_result_o  out  1  one-cycle pulse when a result arrives for a free slot

Behaviour:
- Reset, asynchronous: all slots free, rr_q=0, lock_q=0, outstanding_o=0, spurious_result_o=0. Every valid output is 0 while in reset.
- Arbitration:
  - If lock_q is clear, grant goes to the first port with valid set, searching from rr_q upward with wrap.
  - If lock_q is set, the grant stays on gnt_q.
  - lock_q is set when the granted port is valid but the issue handshake did not complete. This holds the grant stable, as CV-X-IF requires.
  - On handshake: rr_q <= (gnt+1) mod NrPorts and lock_q <= 0.
- Slot allocation:
  - The free slot is the lowest-index free entry; cop_issue_id_o equals that index.
  - cop_issue_valid_o = valid of the granted port AND at least one slot free. With all slots full it stays 0, no handshake occurs, and the grant is not locked.
  - req_issue_ready_o[gnt] = cop_issue_ready_i AND cop_issue_valid_o. The other bits are 0.
  - Instruction, operands and accept pass through combinationally, zero added latency.
- On an issue handshake with accept=1: the slot becomes busy and stores {port index, requester ID}. With accept=0 nothing is allocated.
- Result routing, combinational:
  - The entry looked up is table[cop_result_id_i].
  - If that entry is busy: req_result_valid_o[port] = cop_result_valid_i; req_result_id_o = the stored ID; data, rd and we pass through; cop_result_ready_o = req_result_ready_i[port].
  - If that entry is free: no requester valid is raised, cop_result_ready_o=1, and spurious_result_o pulses on the following cycle (registered).
  - On a result handshake the slot is freed.
- Same-cycle allocate and free:
  - Allocation uses the free mask from before this cycle's free, so a slot freed this cycle becomes allocatable next cycle.
  - The allocated slot and the freed slot are never the same slot.
  - outstanding_o updates by +1, -1, or 0 when both occur.
- The block adds no commit or kill handling; requesters must only issue instructions that will commit.

Decomposition:
- Package cvxif_arb_pkg holds:
  - the slot_entry_t struct {busy, port idx [$clog2(NrPorts)-1:0], id [IdWidth-1:0]};
  - a default NrSlots function;
  - packed per-port issue/result typedefs.
- Sub-module rr_arb_lock contains the round-robin pointer, the lock register and the grant logic, and is reusable elsewhere. The table stays in the top module.

Test Plan:
- Port0 issues id=5 and the coprocessor accepts; later a result arrives with id=0 -> port0 result_valid=1, req_result_id_o=5, outstanding_o goes 1 -> 0.
- Both ports valid every cycle, cop_issue_ready_i=1 -> grants alternate 0,1,0,1, and slot IDs come out 0,1,2,3.
- Port1 valid while cop_issue_ready_i is held low for 3 cycles and port0 turns valid during that time -> grant stays on port1 until its handshake; port0 is granted next.
- 8 accepted issues with no results -> outstanding_o=8, cop_issue_valid_o=0 and no requester ready; one result for slot 3 frees it, and the next issue gets cop_issue_id_o=3.
- Issue with cop_issue_accept_i=0 -> req_issue_accept_o=0, no slot allocated, outstanding_o unchanged.
- Result for a free slot 6 -> cop_result_ready_o=1, no requester valid, spurious_result_o pulses for exactly 1 cycle.
- rst_ni asserted with 4 slots outstanding -> outputs immediately 0 and the table is cleared; after release the first issue gets slot 0.

Source files
------------

// File: rtl/cvxif_arb_pkg.sv
// -----------------------------------------------------------------------------
// cvxif_arb_pkg
// Shared types and defaults for the CV-X-IF issue arbiter.
//   NR_PORTS / ID_WIDTH / REG_WIDTH : default configuration of the arbiter
//   nr_slots()                       : outstanding-table depth for an ID width
//   slot_entry_t                     : one outstanding-table entry
//   issue_req_t / result_t           : packed per-port issue and result bundles
// -----------------------------------------------------------------------------
package cvxif_arb_pkg;

  localparam int unsigned NR_PORTS  = 2;
  localparam int unsigned ID_WIDTH  = 3;
  localparam int unsigned REG_WIDTH = 64;
  localparam int unsigned PORT_W    = $clog2(NR_PORTS);

  // Every coprocessor-side ID maps to exactly one table slot.
  function automatic int unsigned nr_slots(input int unsigned id_width);
    return 32'd1 << id_width;
  endfunction

  typedef struct packed {
    logic                busy;
    logic [PORT_W-1:0]   port;
    logic [ID_WIDTH-1:0] id;
  } slot_entry_t;

  typedef struct packed {
    logic [31:0]            instr;
    logic [2*REG_WIDTH-1:0] rs;
    logic [ID_WIDTH-1:0]    id;
  } issue_req_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [REG_WIDTH-1:0] data;
    logic [4:0]           rd;
    logic                 we;
  } result_t;

endpackage

// File: rtl/cvxif_issue_arbiter_if.sv
// -----------------------------------------------------------------------------
// cvxif_issue_arbiter_if
// Bundles the requester-side and coprocessor-side CV-X-IF issue/result signals.
// Suffixes _i/_o are from the arbiter's point of view.
//   modport slave  : the arbiter
//   modport master : the environment (requesters + coprocessor)
// -----------------------------------------------------------------------------
interface cvxif_issue_arbiter_if #(
  parameter int unsigned NrPorts  = cvxif_arb_pkg::NR_PORTS,
  parameter int unsigned IdWidth  = cvxif_arb_pkg::ID_WIDTH,
  parameter int unsigned RegWidth = cvxif_arb_pkg::REG_WIDTH
);
  // requester side
  logic [NrPorts-1:0]            req_issue_valid_i;
  logic [NrPorts-1:0]            req_issue_ready_o;
  logic                          req_issue_accept_o;
  logic [NrPorts*32-1:0]         req_issue_instr_i;
  logic [NrPorts*2*RegWidth-1:0] req_issue_rs_i;
  logic [NrPorts*IdWidth-1:0]    req_issue_id_i;
  logic [NrPorts-1:0]            req_result_valid_o;
  logic [NrPorts-1:0]            req_result_ready_i;
  logic [IdWidth-1:0]            req_result_id_o;
  logic [RegWidth-1:0]           req_result_data_o;
  logic [4:0]                    req_result_rd_o;
  logic                          req_result_we_o;
  // coprocessor side
  logic                          cop_issue_valid_o;
  logic                          cop_issue_ready_i;
  logic                          cop_issue_accept_i;
  logic [31:0]                   cop_issue_instr_o;
  logic [2*RegWidth-1:0]         cop_issue_rs_o;
  logic [IdWidth-1:0]            cop_issue_id_o;
  logic                          cop_result_valid_i;
  logic                          cop_result_ready_o;
  logic [IdWidth-1:0]            cop_result_id_i;
  logic [RegWidth-1:0]           cop_result_data_i;
  logic [4:0]                    cop_result_rd_i;
  logic                          cop_result_we_i;

  modport slave (
    input  req_issue_valid_i, req_issue_instr_i, req_issue_rs_i, req_issue_id_i,
           req_result_ready_i, cop_issue_ready_i, cop_issue_accept_i,
           cop_result_valid_i, cop_result_id_i, cop_result_data_i,
           cop_result_rd_i, cop_result_we_i,
    output req_issue_ready_o, req_issue_accept_o, req_result_valid_o,
           req_result_id_o, req_result_data_o, req_result_rd_o, req_result_we_o,
           cop_issue_valid_o, cop_issue_instr_o, cop_issue_rs_o, cop_issue_id_o,
           cop_result_ready_o
  );

  modport master (
    output req_issue_valid_i, req_issue_instr_i, req_issue_rs_i, req_issue_id_i,
           req_result_ready_i, cop_issue_ready_i, cop_issue_accept_i,
           cop_result_valid_i, cop_result_id_i, cop_result_data_i,
           cop_result_rd_i, cop_result_we_i,
    input  req_issue_ready_o, req_issue_accept_o, req_result_valid_o,
           req_result_id_o, req_result_data_o, req_result_rd_o, req_result_we_o,
           cop_issue_valid_o, cop_issue_instr_o, cop_issue_rs_o, cop_issue_id_o,
           cop_result_ready_o
  );
endinterface

// File: rtl/rr_arb_lock.sv
// -----------------------------------------------------------------------------
// rr_arb_lock
// Round-robin arbiter whose grant is frozen while a granted request is pending.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_valid       : per-port requests
//   i_active      : the granted request is actually presented downstream
//   i_handshake   : the presented request completed this cycle
//   o_gnt         : granted port index
//   o_gnt_valid   : the granted port is requesting
// -----------------------------------------------------------------------------
module rr_arb_lock #(
  parameter int unsigned NrPorts = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NrPorts-1:0]         i_valid,
  input  logic                       i_active,
  input  logic                       i_handshake,
  output logic [$clog2(NrPorts)-1:0] o_gnt,
  output logic                       o_gnt_valid
);
  localparam int unsigned PortW = $clog2(NrPorts);

  logic [PortW-1:0] r_rr;
  logic [PortW-1:0] r_gnt;
  logic             r_lock;
  logic [PortW-1:0] w_search;
  logic [PortW-1:0] w_idx;

  // Walk from the highest offset down so the last hit is the first valid port
  // at or after r_rr (with wrap).
  always_comb begin
    w_search = r_rr;
    w_idx    = '0;
    for (int i = int'(NrPorts) - 1; i >= 0; i--) begin
      w_idx = PortW'((int'(r_rr) + i) % int'(NrPorts));
      if (i_valid[w_idx]) w_search = w_idx;
    end
  end

  assign o_gnt       = r_lock ? r_gnt : w_search;
  assign o_gnt_valid = i_valid[o_gnt];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr   <= '0;
      r_gnt  <= '0;
      r_lock <= 1'b0;
    end else begin
      r_gnt <= o_gnt;
      if (i_handshake) begin
        r_rr   <= (o_gnt == PortW'(NrPorts - 1)) ? '0 : o_gnt + PortW'(1);
        r_lock <= 1'b0;
      end else begin
        // Only a request that is really on the bus is held; a request stalled
        // by a full table is free to lose the grant.
        r_lock <= i_active;
      end
    end
  end
endmodule

// File: rtl/cvxif_issue_arbiter.sv
// -----------------------------------------------------------------------------
// cvxif_issue_arbiter
// Shares one CV-X-IF coprocessor between NrPorts requesters. Issues are
// arbitrated round-robin, each accepted instruction gets a coprocessor-side ID
// (a slot in the outstanding table), and results are routed back to the
// issuing requester with its original ID.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   bus (slave)       : requester and coprocessor issue/result channels
//   outstanding_o     : number of busy slots
//   spurious_result_o : one-cycle pulse after a result for a free slot
// -----------------------------------------------------------------------------
module cvxif_issue_arbiter
  import cvxif_arb_pkg::*;
#(
  parameter int unsigned NrPorts  = NR_PORTS,
  parameter int unsigned IdWidth  = ID_WIDTH,
  parameter int unsigned RegWidth = REG_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cvxif_issue_arbiter_if.slave bus,
  output logic [IdWidth:0]     outstanding_o,
  output logic                 spurious_result_o
);
  localparam int unsigned NrSlots = nr_slots(IdWidth);
  localparam int unsigned PortW   = $clog2(NrPorts);
  localparam int unsigned OutW    = IdWidth + 1;

  logic [PortW-1:0]   w_gnt;
  logic               w_gnt_valid;
  logic               w_any_free;
  logic [IdWidth-1:0] w_free_idx;
  logic               w_issue_valid;
  logic               w_issue_out;
  logic               w_issue_hs;
  logic               w_alloc;
  issue_req_t         w_gnt_req;
  slot_entry_t        w_res_entry;
  result_t            w_res_out;
  logic               w_res_hs;

  slot_entry_t        r_table [NrSlots];
  logic [OutW-1:0]    r_outstanding;
  logic               r_spurious;

  rr_arb_lock #(.NrPorts(NrPorts)) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_valid    (bus.req_issue_valid_i),
    .i_active   (w_issue_valid),
    .i_handshake(w_issue_hs),
    .o_gnt      (w_gnt),
    .o_gnt_valid(w_gnt_valid)
  );

  // Lowest-index free slot, taken from the table state before this cycle's free.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int s = int'(NrSlots) - 1; s >= 0; s--) begin
      if (!r_table[s].busy) begin
        w_any_free = 1'b1;
        w_free_idx = IdWidth'(s);
      end
    end
  end

  assign w_gnt_req.instr = bus.req_issue_instr_i[w_gnt*32 +: 32];
  assign w_gnt_req.rs    = bus.req_issue_rs_i[w_gnt*2*RegWidth +: 2*RegWidth];
  assign w_gnt_req.id    = bus.req_issue_id_i[w_gnt*IdWidth +: IdWidth];

  assign w_issue_valid = w_gnt_valid & w_any_free;
  assign w_issue_out   = w_issue_valid & rst_ni;
  assign w_issue_hs    = w_issue_out & bus.cop_issue_ready_i;
  assign w_alloc       = w_issue_hs & bus.cop_issue_accept_i;

  assign bus.cop_issue_valid_o  = w_issue_out;
  assign bus.cop_issue_instr_o  = w_gnt_req.instr;
  assign bus.cop_issue_rs_o     = w_gnt_req.rs;
  assign bus.cop_issue_id_o     = w_free_idx;
  assign bus.req_issue_accept_o = bus.cop_issue_accept_i & w_issue_hs;

  // Result lookup: the coprocessor ID indexes the table directly.
  assign w_res_entry = r_table[bus.cop_result_id_i];
  assign w_res_out   = '{id:   w_res_entry.id,
                         data: bus.cop_result_data_i,
                         rd:   bus.cop_result_rd_i,
                         we:   bus.cop_result_we_i};

  // A result for a free slot is drained so the coprocessor never stalls on it.
  assign bus.cop_result_ready_o = w_res_entry.busy ? bus.req_result_ready_i[w_res_entry.port] : 1'b1;
  assign w_res_hs = bus.cop_result_valid_i & bus.cop_result_ready_o & w_res_entry.busy;

  assign bus.req_result_id_o   = w_res_out.id;
  assign bus.req_result_data_o = w_res_out.data;
  assign bus.req_result_rd_o   = w_res_out.rd;
  assign bus.req_result_we_o   = w_res_out.we;

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_port
    assign bus.req_issue_ready_o[gi]  = (w_gnt == PortW'(gi)) & w_issue_hs;
    assign bus.req_result_valid_o[gi] = w_res_entry.busy & (w_res_entry.port == PortW'(gi))
                                        & bus.cop_result_valid_i & rst_ni;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(NrSlots); s++) r_table[s] <= '0;
      r_outstanding <= '0;
      r_spurious    <= 1'b0;
    end else begin
      // The allocated slot was free and the freed slot was busy, so the two
      // branches never target the same entry.
      for (int s = 0; s < int'(NrSlots); s++) begin
        if (w_alloc && (w_free_idx == IdWidth'(s))) begin
          r_table[s] <= '{busy: 1'b1, port: w_gnt, id: w_gnt_req.id};
        end else if (w_res_hs && (bus.cop_result_id_i == IdWidth'(s))) begin
          r_table[s].busy <= 1'b0;
        end
      end
      case ({w_alloc, w_res_hs})
        2'b10:   r_outstanding <= r_outstanding + OutW'(1);
        2'b01:   r_outstanding <= r_outstanding - OutW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      r_spurious <= bus.cop_result_valid_i & ~w_res_entry.busy;
    end
  end

  assign outstanding_o     = r_outstanding;
  assign spurious_result_o = r_spurious;
endmodule
